// File: rtl/tt_sweep_pkg.sv
// Shared types and width helpers for the truth-table sweep sequencer.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam int CNT_W_MIN = 1;

  function automatic int tbl_w(input int n);
    return 1 << n;
  endfunction

  // A settle time of one cycle still needs a one-bit counter.
  function automatic int cnt_w(input int settle);
    return (settle > 1) ? $clog2(settle) : CNT_W_MIN;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-time counter: counts 0..SETTLE-1 while enabled, tick marks the last count.
module tt_settle_timer
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = cnt_w(SETTLE);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_sweep.sv
// Walks every input vector of a gate, samples its output after SETTLE cycles and builds
// the truth table on port tbl ('table' is a reserved word). TT_CHECK_EN adds expected/match.
module truth_table_sweep
  import tt_sweep_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic [N_IN-1:0]           dut_in,
  input  logic                      dut_out,
  output logic [tbl_w(N_IN)-1:0]    tbl
`ifdef TT_CHECK_EN
  ,
  input  logic [tbl_w(N_IN)-1:0]    expected,
  output logic                      match
`endif
);

  localparam int TW = tbl_w(N_IN);

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [TW-1:0]   tbl_q, tbl_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tick, timer_clear, timer_en;

  assign timer_en    = (state_q == S_SETTLE);
  assign timer_clear = (state_q != S_SETTLE) || abort;

  tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_en),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tbl_d   = tbl_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_SETTLE;
          idx_d   = '0;
          tbl_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_SETTLE: begin
        // Abort keeps the bits already sampled so a host can inspect a partial sweep.
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
        end else if (tick) begin
          tbl_d[idx_q] = dut_out;
          if (idx_q == '1) begin
            idx_d   = '0;
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + N_IN'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tbl_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tbl_q   <= tbl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign dut_in = idx_q;
  assign tbl    = tbl_q;

`ifdef TT_CHECK_EN
  logic match_q, match_d;

  // Compare against the table as it will be after the final sample, so match lines up with done.
  always_comb begin
    match_d = match_q;
    if (abort) begin
      match_d = 1'b0;
    end else if (state_q == S_IDLE && start) begin
      match_d = 1'b0;
    end else if (state_q == S_SETTLE && state_d == S_DONE) begin
      match_d = (tbl_d == expected);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign match = match_q;
`endif

endmodule

// File: tb/tb_truth_table_sweep.sv
// Bench for truth_table_sweep: two instances (SETTLE=4 and SETTLE=1) driving behavioural gates.
module tb_truth_table_sweep;

  localparam int N  = 3;
  localparam int TW = 8;
  localparam int S0 = 4;
  localparam int S1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          start0 = 1'b0, abort0 = 1'b0, busy0, done0, dout0;
  logic [N-1:0]  din0;
  logic [TW-1:0] tbl0, fn0 = '0;
  logic          start1 = 1'b0, abort1 = 1'b0, busy1, done1, dout1;
  logic [N-1:0]  din1;
  logic [TW-1:0] tbl1, fn1 = '0;
`ifdef TT_CHECK_EN
  logic [TW-1:0] exp0 = '0, exp1 = '0;
  logic          match0, match1;
`endif

  // Behavioural gates: output is the function's truth table indexed by the input vector.
  assign dout0 = fn0[din0];
  assign dout1 = fn1[din1];

  logic [TW-1:0] last_tbl0 = '0;
  int checks = 0;
  int errors = 0;

  truth_table_sweep #(.N_IN(N), .SETTLE(S0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .busy(busy0), .done(done0),
    .dut_in(din0), .dut_out(dout0), .tbl(tbl0)
`ifdef TT_CHECK_EN
    , .expected(exp0), .match(match0)
`endif
  );

  truth_table_sweep #(.N_IN(N), .SETTLE(S1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .busy(busy1), .done(done1),
    .dut_in(din1), .dut_out(dout1), .tbl(tbl1)
`ifdef TT_CHECK_EN
    , .expected(exp1), .match(match1)
`endif
  );

  task automatic test_reset();
    logic [N+TW+1:0] got;
    #1 rst_n = 1'b0;
    #1;
    got = {busy0, done0, din0, tbl0};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_u0 got %h want 0", got);
    end
    got = {busy1, done1, din1, tbl1};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_u1 got %h want 0", got);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      got = {busy0, done0, din0, tbl0};
      checks++;
      if (got !== '0) begin
        errors++;
        $display("FAIL idle_after_reset k=%0d got %h want 0", k, got);
      end
    end
  endtask

  task automatic test_sweep(input logic [TW-1:0] fn, input bit poke);
    logic [N+1:0] got, want;
    fn0 = fn;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int k = 0; k <= TW*S0 + 1; k++) begin
      if (k > 0) @(negedge clk);
      want = {k < TW*S0, k == TW*S0, (k < TW*S0) ? N'(k / S0) : N'(0)};
      got  = {busy0, done0, din0};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL sweep k=%0d busy/done/din got %b want %b", k, got, want);
      end
      if (k >= TW*S0) begin
        checks++;
        if (tbl0 !== fn) begin
          errors++;
          $display("FAIL sweep_table k=%0d got %h want %h", k, tbl0, fn);
        end
      end
`ifdef TT_CHECK_EN
      if (k == 0 || k == TW*S0) begin
        checks++;
        if (match0 !== (k == 0 ? 1'b0 : (fn == exp0))) begin
          errors++;
          $display("FAIL sweep_match k=%0d got %b want %b", k, match0, (k != 0) && (fn == exp0));
        end
      end
`endif
      start0 = poke && (k == 5 || k == 20 || k == TW*S0 - 1 || k == TW*S0);
    end
    last_tbl0 = fn;
  endtask

  task automatic test_abort(input logic [TW-1:0] fn, input int at);
    logic [N+1:0]  got, want;
    logic [TW-1:0] partial;
    partial = fn & TW'((1 << ((at - 1) / S0)) - 1);
    fn0 = fn;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int k = 0; k <= at + 3; k++) begin
      if (k > 0) @(negedge clk);
      want = (k < at) ? {1'b1, 1'b0, N'(k / S0)} : '0;
      got  = {busy0, done0, din0};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL abort at=%0d k=%0d busy/done/din got %b want %b", at, k, got, want);
      end
      if (k >= at) begin
        checks++;
        if (tbl0 !== partial) begin
          errors++;
          $display("FAIL abort_table at=%0d k=%0d got %h want %h", at, k, tbl0, partial);
        end
`ifdef TT_CHECK_EN
        checks++;
        if (match0 !== 1'b0) begin
          errors++;
          $display("FAIL abort_match k=%0d got %b want 0", k, match0);
        end
`endif
      end
      abort0 = (k == at - 1);
    end
    last_tbl0 = partial;
  endtask

  task automatic test_start_abort_idle();
    logic [N+1:0] got;
    fn0 = TW'($urandom);
    @(negedge clk); start0 = 1'b1; abort0 = 1'b1;
    @(negedge clk); start0 = 1'b0; abort0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      got = {busy0, done0, din0};
      checks++;
      if (got !== '0 || tbl0 !== last_tbl0) begin
        errors++;
        $display("FAIL start_abort_idle k=%0d ctl %b tbl %h want ctl 0 tbl %h", k, got, tbl0, last_tbl0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] r;
    r = TW'($urandom);
    test_sweep(r, 1'b1);
    test_sweep(8'hC0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [N+TW+1:0] got;
    fn0 = TW'($urandom) | 8'h01;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = {busy0, done0, din0, tbl0};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_mid_u0 got %h want 0", got);
    end
    got = {busy1, done1, din1, tbl1};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_mid_u1 got %h want 0", got);
    end
`ifdef TT_CHECK_EN
    checks++;
    if ({match0, match1} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_match got %b want 00", {match0, match1});
    end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_tbl0 = '0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({busy0, done0, din0, tbl0} !== '0) begin
        errors++;
        $display("FAIL after_reset_idle got %h want 0", {busy0, done0, din0, tbl0});
      end
    end
  endtask

  task automatic test_settle1(input logic [TW-1:0] fn);
    logic [N+1:0] got, want;
    fn1 = fn;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int k = 0; k <= TW*S1 + 1; k++) begin
      if (k > 0) @(negedge clk);
      want = {k < TW*S1, k == TW*S1, (k < TW*S1) ? N'(k / S1) : N'(0)};
      got  = {busy1, done1, din1};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL settle1 k=%0d busy/done/din got %b want %b", k, got, want);
      end
      if (k >= TW*S1) begin
        checks++;
        if (tbl1 !== fn) begin
          errors++;
          $display("FAIL settle1_table k=%0d got %h want %h", k, tbl1, fn);
        end
      end
`ifdef TT_CHECK_EN
      if (k == TW*S1) begin
        checks++;
        if (match1 !== (fn == exp1)) begin
          errors++;
          $display("FAIL settle1_match got %b want %b", match1, fn == exp1);
        end
      end
`endif
    end
  endtask

`ifdef TT_CHECK_EN
  task automatic test_match();
    exp0 = 8'hC0;
    test_sweep(8'hC0, 1'b0);
    exp0 = 8'h80;
    test_sweep(8'hC0, 1'b0);
    exp1 = 8'hC0;
    test_settle1(8'hC0);
    exp1 = 8'h80;
    test_settle1(8'hC0);
  endtask
`endif

  initial begin
    logic [TW-1:0] r;
    test_reset();
    test_sweep(8'hC0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      r = TW'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      test_sweep(r, 1'b0);
    end
    test_abort(8'hC0, 10);
    test_sweep(8'hC0, 1'b0);
    r = TW'($urandom);
    test_abort(r, 10);
    test_abort(TW'($urandom), $urandom_range(2, TW*S0 - 1));
    test_start_abort_idle();
    test_back_to_back();
    test_start_abort_idle();
    test_reset_mid();
    test_sweep(TW'($urandom), 1'b0);
    test_settle1(8'hC0);
    test_settle1(TW'($urandom));
`ifdef TT_CHECK_EN
    test_match();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
